store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, >=2).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port st_valid  input  1  MEM stage presents a store this cycle.
REQ-005 SHALL have port st_ready  output  1  buffer can accept a store.
REQ-006 SHALL have port st_addr  input  32  store byte address.
REQ-007 SHALL have port st_data  input  32  raw rs2 value.
REQ-008 SHALL have port fu3  input  3  funct3 (0 sb, 1 sh, 2 sw).
REQ-009 SHALL have port st_byte_en  input  4  lane enables from the store unit.
REQ-010 SHALL have port mem_req_valid  output  1  head store presented to data memory.
REQ-011 SHALL have port mem_req_ready  input  1  data memory accepts the head.
REQ-012 SHALL have port mem_req_addr  output  32  word address, bits [1:0] forced to 0.
REQ-013 SHALL have port mem_req_wdata  output  32  lane-aligned write data.
REQ-014 SHALL have port mem_req_wstrb  output  4  byte strobes.
REQ-015 SHALL have port ld_check  input  1  load in MEM stage needs a hazard check.
REQ-016 SHALL have port ld_addr  input  32  load byte address.
REQ-017 SHALL have port ld_hazard  output  1  load must stall; pending store overlaps it.
REQ-018 SHALL have port empty  output  1  no store pending (used for fence/drain).

Function
REQ-019 SHALL be a circular FIFO of DEPTH entries {word addr[31:2], wdata, wstrb} with wrapping read/write pointers and a count of width clog2(DEPTH)+1.
REQ-020 SHALL drive st_ready = (count != DEPTH); a push when full is never accepted, even with a simultaneous pop.
REQ-021 SHALL push on st_valid && st_ready; pop on mem_req_valid && mem_req_ready; simultaneous push and pop leaves count unchanged.
REQ-022 SHALL align data at push: fu3=0 -> {4{st_data[7:0]}}; fu3=1 -> {2{st_data[15:0]}}; otherwise st_data.
REQ-023 SHALL store wstrb = st_byte_en unchanged.
REQ-024 SHALL drive mem_req_valid = (count != 0), with addr/wdata/wstrb taken from the head entry.
REQ-025 SHALL hold mem_req_* stable while mem_req_valid && !mem_req_ready.
REQ-026 SHALL have latency: a store pushed in cycle N into an empty buffer appears on mem_req in cycle N+1; there is no same-cycle bypass.
REQ-027 SHALL drive ld_hazard = ld_check && (any valid entry has word address == ld_addr[31:2]); this is combinational, and the entry being popped in the current cycle still counts.
REQ-028 SHALL exclude from the hazard check a store being pushed in the same cycle (only one memory op issues per cycle).
REQ-029 SHALL drive empty = (count == 0).
REQ-030 SHALL handle pointer wrap from DEPTH-1 to 0 with no bubble.

Reset
REQ-031 SHALL clear pointers and count on rst asynchronously, giving st_ready=1, mem_req_valid=0, ld_hazard=0 and empty=1.
REQ-032 SHALL discard all pending stores when reset is asserted mid-drain.
REQ-033 SHALL not reset the entry storage; its contents are don't-care while invalid.

Structure
REQ-034 SHALL place the funct3 store encodings (SB/SH/SW) in the shared core package.
REQ-035 SHALL use one sub-module, sb_align, holding the REQ-022 data replication.

Verification
REQ-036 SHALL cover: sb addr 0x103, data 0xAABBCCDD, byte_en 1000, mem_req_ready=1 -> next cycle addr 0x100, wdata 0xDDDDDDDD, wstrb 1000, then empty=1.
REQ-037 SHALL cover: 4 sw pushes with mem_req_ready=0 -> st_ready=0 after the 4th; a 5th push is not accepted; on ready=1, the four drain in order, one per cycle.
REQ-038 SHALL cover: buffer full plus simultaneous st_valid and pop -> pop occurs, push is refused, and count goes from 4 to 3.
REQ-039 SHALL cover: sh to 0x202 pending, ld_check with ld_addr 0x200 -> ld_hazard=1; ld_addr 0x204 -> ld_hazard=0.
REQ-040 SHALL cover: 6 push/pop pairs cycling pointers past wrap -> data order preserved and count never exceeds 1.
REQ-041 SHALL cover: rst asserted with 3 entries pending and ready=0 -> mem_req_valid=0 and empty=1 immediately, with no write issued afterwards.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: funct3 store encodings and the
// layout of one buffered store.
package store_buffer_pkg;

  typedef enum logic [2:0] {
    FuSb = 3'd0,
    FuSh = 3'd1,
    FuSw = 3'd2
  } store_fu_e;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_align.sv
// Replicates the store operand across byte lanes according to the store width,
// so the strobes alone select which bytes memory writes.
module sb_align
  import store_buffer_pkg::*;
(
  input  logic [2:0]  fu3,
  input  logic [31:0] st_data,
  output logic [31:0] wdata
);

  always_comb begin
    wdata = st_data;
    case (fu3)
      FuSb:    wdata = {4{st_data[7:0]}};
      FuSh:    wdata = {2{st_data[15:0]}};
      default: wdata = st_data;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between the MEM stage and data memory, with a
// combinational word-address hazard check for loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  fu3,
  input  logic [3:0]  st_byte_en,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        ld_check,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  sb_entry_t       mem_q [DEPTH];
  sb_entry_t       entry_in, head;
  logic [31:0]     aligned_data;
  logic            push, pop;

  sb_align u_align (
    .fu3     (fu3),
    .st_data (st_data),
    .wdata   (aligned_data)
  );

  assign st_ready      = (count_q != CntW'(DEPTH));
  assign mem_req_valid = (count_q != '0);
  assign empty         = (count_q == '0);
  assign push          = st_valid && st_ready;
  assign pop           = mem_req_valid && mem_req_ready;

  assign entry_in = '{waddr: st_addr[31:2], wdata: aligned_data, wstrb: st_byte_en};
  assign head     = mem_q[rd_ptr_q];

  assign mem_req_addr  = {head.waddr, 2'b00};
  assign mem_req_wdata = head.wdata;
  assign mem_req_wstrb = head.wstrb;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_in;
  end

  // An entry is live when its distance from the head is below the count; the
  // store being pushed this cycle is not yet live, the one being popped still is.
  always_comb begin
    logic [PtrW-1:0] offset;
    logic            hit;
    offset = '0;
    hit    = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PtrW'(i) - rd_ptr_q;
      if (({1'b0, offset} < count_q) && (mem_q[i].waddr == ld_addr[31:2])) hit = 1'b1;
    end
    ld_hazard = ld_check && hit;
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the buffer.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  fu3;
  logic [3:0]  st_byte_en;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        empty;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .fu3           (fu3),
    .st_byte_en    (st_byte_en),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .ld_check      (ld_check),
    .ld_addr       (ld_addr),
    .ld_hazard     (ld_hazard),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ref_store_t;

  ref_store_t model_q[$];
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_align(input logic [2:0] f, input logic [31:0] d);
    if (f == 3'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (f == 3'd1) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic ref_hazard(input logic chk, input logic [31:0] la);
    if (!chk) return 1'b0;
    foreach (model_q[k]) if (model_q[k].addr == {la[31:2], 2'b00}) return 1'b1;
    return 1'b0;
  endfunction

  // Entered just after a falling edge: drive, check, take the rising edge, update model.
  task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [2:0] f, input logic [3:0] be, input logic rdy,
                       input logic lc, input logic [31:0] la);
    logic do_push, do_pop;
    ref_store_t s;
    st_valid = sv; st_addr = sa; st_data = sd; fu3 = f; st_byte_en = be;
    mem_req_ready = rdy; ld_check = lc; ld_addr = la;
    #1;
    check("st_ready", 32'(st_ready), 32'(model_q.size() != DEPTH));
    check("mem_req_valid", 32'(mem_req_valid), 32'(model_q.size() != 0));
    check("empty", 32'(empty), 32'(model_q.size() == 0));
    check("ld_hazard", 32'(ld_hazard), 32'(ref_hazard(lc, la)));
    if (model_q.size() != 0) begin
      check("mem_req_addr", mem_req_addr, model_q[0].addr);
      check("mem_req_wdata", mem_req_wdata, model_q[0].data);
      check("mem_req_wstrb", 32'(mem_req_wstrb), 32'(model_q[0].strb));
    end
    do_push = sv && (model_q.size() != DEPTH);
    do_pop  = rdy && (model_q.size() != 0);
    @(posedge clk);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) begin
      s.addr = {sa[31:2], 2'b00};
      s.data = ref_align(f, sd);
      s.strb = be;
      model_q.push_back(s);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 32'h0, 32'h0, 3'd2, 4'h0, rdy, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0; fu3 = '0; st_byte_en = '0;
    mem_req_ready = 1'b0; ld_check = 1'b1; ld_addr = '0;
    #12;
    check("rst_st_ready", 32'(st_ready), 32'd1);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_ld_hazard", 32'(ld_hazard), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Byte store replicated across lanes, drained next cycle.
    cycle(1'b1, 32'h103, 32'hAABBCCDD, 3'd0, 4'b1000, 1'b1, 1'b0, 32'h0);
    #1;
    check("sb_addr", mem_req_addr, 32'h100);
    check("sb_wdata", mem_req_wdata, 32'hDDDDDDDD);
    check("sb_wstrb", 32'(mem_req_wstrb), 32'b1000);
    idle(1'b1);
    #1;
    check("sb_drained_empty", 32'(empty), 32'd1);

    // Fill with ready low, fifth push refused, then drain in order.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h400 + 32'(i * 4), 32'h1000_0000 + 32'(i), 3'd2, 4'hF, 1'b0, 1'b0, 32'h0);
    #1;
    check("full_st_ready", 32'(st_ready), 32'd0);
    cycle(1'b1, 32'h500, 32'hDEADBEEF, 3'd2, 4'hF, 1'b0, 1'b0, 32'h0);
    // Full with simultaneous push and pop: pop only, count 4 -> 3.
    cycle(1'b1, 32'h504, 32'hBAD0BAD0, 3'd2, 4'hF, 1'b1, 1'b0, 32'h0);
    #1;
    check("after_full_pop_ready", 32'(st_ready), 32'd1);
    check("after_full_pop_head", mem_req_wdata, 32'h1000_0001);
    for (int i = 0; i < 3; i++) idle(1'b1);
    #1;
    check("full_drained_empty", 32'(empty), 32'd1);

    // Halfword store hazard against same and neighbouring words.
    cycle(1'b1, 32'h202, 32'h1234_5678, 3'd1, 4'b1100, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 3'd2, 4'h0, 1'b0, 1'b1, 32'h200);
    #1;
    ld_addr = 32'h200;
    #1;
    check("sh_hazard_hit", 32'(ld_hazard), 32'd1);
    check("sh_wdata", mem_req_wdata, 32'h56785678);
    ld_addr = 32'h204;
    #1;
    check("sh_hazard_miss", 32'(ld_hazard), 32'd0);
    @(negedge clk);
    // Popping entry still hazards; pushed same-word store does not.
    cycle(1'b1, 32'h200, 32'h0, 3'd2, 4'hF, 1'b1, 1'b1, 32'h200);
    cycle(1'b1, 32'h300, 32'h0, 3'd2, 4'hF, 1'b1, 1'b1, 32'h300);
    idle(1'b1);

    // Push/pop pairs carrying pointers past the wrap point.
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 32'h600 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 3'd2, 4'hF, 1'b1, 1'b0, 32'h0);
    idle(1'b1);
    #1;
    check("wrap_drained_empty", 32'(empty), 32'd1);
    @(negedge clk);

    // Reset mid-drain discards pending stores immediately.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h700 + 32'(i * 4), 32'h7700_0000 + 32'(i), 3'd2, 4'hF, 1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Random traffic over a small address window so hazards occur.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 31)), $urandom,
            3'($urandom_range(0, 3)), 4'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 31)));
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    #1;
    check("final_empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
